// File: rtl/systolic_array_ctrl.sv
// systolic_array_ctrl
//   Sequencer for a 4x4 systolic_array datapath. Operand matrices A (west
//   side) and B (north side) live in local register files loaded from a host
//   write port. A start request clears the array, streams skewed operands
//   onto the 8 edge inputs, then waits for the array's done (or a timeout)
//   and reports completion with a one-cycle done pulse or a sticky err flag.
//
// Ports
//   clk            rising-edge clock
//   rst            asynchronous, active-low reset
//   wr_en          operand write strobe
//   wr_sel         0 = write A, 1 = write B
//   wr_row/wr_col  element index of the write
//   wr_data        operand value
//   start          begin a multiply (only honoured in IDLE)
//   busy           high from the cycle after start is accepted until FINISH/ERR exits
//   done           one-cycle pulse on successful completion
//   err            sticky timeout flag, cleared by the next accepted start
//   arr_rst        active-high clear to the array
//   arr_done       array's done output (only looked at in DRAIN)
//   west0..3       array west inputs
//   north0..3      array north inputs
//   state_dbg      current FSM state encoding, for observation
//
// Host interface handshake: there is no ready signal. A write is taken on
// any rising edge where wr_en=1 and busy=0; otherwise it is dropped. start
// is taken on any rising edge where the FSM is in IDLE; a write and a start
// on the same edge both take effect (the write lands before the run reads
// the matrices). Requests that are not taken are not queued.
module systolic_array_ctrl #(
    parameter int DW      = 32,
    parameter int N       = 4,
    parameter int TIMEOUT = 64
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic          wr_sel,
    input  logic [1:0]    wr_row,
    input  logic [1:0]    wr_col,
    input  logic [DW-1:0] wr_data,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          arr_rst,
    input  logic          arr_done,
    output logic [DW-1:0] west0,
    output logic [DW-1:0] west1,
    output logic [DW-1:0] west2,
    output logic [DW-1:0] west3,
    output logic [DW-1:0] north0,
    output logic [DW-1:0] north1,
    output logic [DW-1:0] north2,
    output logic [DW-1:0] north3,
    output logic [2:0]    state_dbg
);

    localparam int         TW        = $clog2(TIMEOUT + 1);
    localparam logic [2:0] LAST_STEP = 3'(2 * N - 2);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLR    = 3'd1,
        S_FEED   = 3'd2,
        S_DRAIN  = 3'd3,
        S_FINISH = 3'd4,
        S_ERR    = 3'd5
    } state_t;

    state_t                         state;
    logic [2:0]                     step;
    logic [TW-1:0]                  tcnt;
    logic [TW-1:0]                  tcnt_inc;
    logic [2:0]                     feed_step;
    logic [N-1:0][N-1:0][DW-1:0]    a_mem;
    logic [N-1:0][N-1:0][DW-1:0]    b_mem;
    logic [N-1:0][DW-1:0]           west_q;
    logic [N-1:0][DW-1:0]           north_q;
    logic [N-1:0][DW-1:0]           west_nx;
    logic [N-1:0][DW-1:0]           north_nx;

    // Operand register files. Writes are locked out while a run is in
    // progress so the streamed operands cannot change under the array.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_mem <= '0;
            b_mem <= '0;
        end else if (wr_en && !busy) begin
            if (wr_sel)
                b_mem[wr_row][wr_col] <= wr_data;
            else
                a_mem[wr_row][wr_col] <= wr_data;
        end
    end

    // Edge outputs are registered, so the values for a step are computed one
    // edge early: in CLR we prepare step 0, in FEED step t we prepare t+1.
    assign feed_step = (state == S_CLR) ? 3'd0 : step + 3'd1;

    // Skew: west_i carries A[i][k] and north_i carries B[k][i] at step i+k.
    always_comb begin
        west_nx  = '0;
        north_nx = '0;
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N; k++) begin
                if (feed_step == 3'(i + k)) begin
                    west_nx[i]  = a_mem[i][k];
                    north_nx[i] = b_mem[k][i];
                end
            end
        end
    end

    // Saturating timeout count for DRAIN.
    assign tcnt_inc = (tcnt == TW'(TIMEOUT)) ? tcnt : tcnt + TW'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            arr_rst <= 1'b1;
            step    <= '0;
            tcnt    <= '0;
            west_q  <= '0;
            north_q <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    arr_rst <= 1'b1;
                    busy    <= 1'b0;
                    west_q  <= '0;
                    north_q <= '0;
                    if (start) begin
                        state <= S_CLR;
                        busy  <= 1'b1;
                        err   <= 1'b0;
                    end
                end
                S_CLR: begin
                    step    <= '0;
                    arr_rst <= 1'b0;
                    west_q  <= west_nx;
                    north_q <= north_nx;
                    state   <= S_FEED;
                end
                S_FEED: begin
                    if (step == LAST_STEP) begin
                        state   <= S_DRAIN;
                        tcnt    <= '0;
                        west_q  <= '0;
                        north_q <= '0;
                    end else begin
                        step    <= step + 3'd1;
                        west_q  <= west_nx;
                        north_q <= north_nx;
                    end
                end
                S_DRAIN: begin
                    tcnt <= tcnt_inc;
                    // arr_done wins over a timeout reached on the same edge.
                    if (arr_done) begin
                        state <= S_FINISH;
                        done  <= 1'b1;
                    end else if (tcnt_inc == TW'(TIMEOUT)) begin
                        state <= S_ERR;
                        err   <= 1'b1;
                    end
                end
                S_FINISH, S_ERR: begin
                    state   <= S_IDLE;
                    busy    <= 1'b0;
                    arr_rst <= 1'b1;
                end
                default: begin
                    state   <= S_IDLE;
                    busy    <= 1'b0;
                    arr_rst <= 1'b1;
                    west_q  <= '0;
                    north_q <= '0;
                end
            endcase
        end
    end

    assign west0     = west_q[0];
    assign west1     = west_q[1];
    assign west2     = west_q[2];
    assign west3     = west_q[3];
    assign north0    = north_q[0];
    assign north1    = north_q[1];
    assign north2    = north_q[2];
    assign north3    = north_q[3];
    assign state_dbg = state;

endmodule

// File: tb/tb_systolic_array_ctrl.sv
// tb_systolic_array_ctrl
//   Self-checking bench for systolic_array_ctrl. Edge outputs during FEED are
//   compared against a table of hand-computed skew vectors; the DRAIN/timeout,
//   write-lockout and asynchronous reset corners use hand-written sequences.
//   Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_systolic_array_ctrl;

    localparam int DW = 32;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CLR    = 3'd1;
    localparam logic [2:0] ST_FEED   = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_FINISH = 3'd4;
    localparam logic [2:0] ST_ERR    = 3'd5;

    // ---------------- clock / reset ----------------
    logic          clk = 1'b0;
    logic          rst = 1'b0;
    always #5 clk = ~clk;

    logic          wr_en = 1'b0;
    logic          wr_sel = 1'b0;
    logic [1:0]    wr_row = '0;
    logic [1:0]    wr_col = '0;
    logic [DW-1:0] wr_data = '0;
    logic          start = 1'b0;
    logic          arr_done = 1'b0;
    logic          busy, done, err, arr_rst;
    logic [DW-1:0] west0, west1, west2, west3;
    logic [DW-1:0] north0, north1, north2, north3;
    logic [2:0]    state_dbg;

    systolic_array_ctrl #(.DW(DW), .N(4), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .wr_en(wr_en), .wr_sel(wr_sel), .wr_row(wr_row), .wr_col(wr_col),
        .wr_data(wr_data), .start(start),
        .busy(busy), .done(done), .err(err), .arr_rst(arr_rst),
        .arr_done(arr_done),
        .west0(west0), .west1(west1), .west2(west2), .west3(west3),
        .north0(north0), .north1(north1), .north2(north2), .north3(north3),
        .state_dbg(state_dbg)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    typedef struct {
        logic [4*DW-1:0] w;
        logic [4*DW-1:0] n;
    } feed_vec_t;

    feed_vec_t tbl[21];

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    function automatic logic [4*DW-1:0] pack4(input int a, input int b, input int c, input int d);
        return {DW'(a), DW'(b), DW'(c), DW'(d)};
    endfunction

    task automatic check(input string name, input logic [4*DW-1:0] act, input logic [4*DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic write_op(input logic sel, input int row, input int col, input int data, input logic with_start);
        @(negedge clk);
        wr_en = 1'b1; wr_sel = sel; wr_row = 2'(row); wr_col = 2'(col); wr_data = DW'(data);
        start = with_start;
        @(negedge clk);
        wr_en = 1'b0; start = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at the negedge of the CLR cycle. inject_at: FEED step at which a
    // write of 99 to A[0][0] plus a start is driven for one cycle. rst_at: FEED
    // step at which reset is asserted mid-cycle (run aborts there).
    task automatic run_feed(input int base, input int inject_at, input int rst_at);
        check("clr_state", 128'(state_dbg), 128'(ST_CLR));
        check("clr_busy", 128'(busy), 128'(1));
        check("clr_arr_rst", 128'(arr_rst), 128'(1));
        for (int t = 0; t < 7; t++) begin
            @(negedge clk);
            if (t == inject_at + 1) begin
                wr_en = 1'b0; start = 1'b0;
            end
            check($sformatf("feed_state_t%0d", t), 128'(state_dbg), 128'(ST_FEED));
            check($sformatf("feed_arr_rst_t%0d", t), 128'(arr_rst), 128'(0));
            check($sformatf("west_v%0d_t%0d", base, t), {west0, west1, west2, west3}, tbl[base + t].w);
            check($sformatf("north_v%0d_t%0d", base, t), {north0, north1, north2, north3}, tbl[base + t].n);
            if (t == inject_at) begin
                wr_en = 1'b1; wr_sel = 1'b0; wr_row = 2'd0; wr_col = 2'd0; wr_data = DW'(99);
                start = 1'b1;
            end
            if (t == rst_at) begin
                #2 rst = 1'b0;
                #1;
                check("rst_edges", {west0, west1, west2, west3, north0, north1, north2, north3} == '0 ? 128'(1) : 128'(0), 128'(1));
                check("rst_arr_rst", 128'(arr_rst), 128'(1));
                check("rst_busy", 128'(busy), 128'(0));
                check("rst_state", 128'(state_dbg), 128'(ST_IDLE));
                return;
            end
        end
    endtask

    // Called right after run_feed. done_at: DRAIN cycle (1-based) in which
    // arr_done is raised; 0 means never.
    task automatic drain(input int done_at, input bit expect_err);
        int n = 0;
        int exp_n;
        int d0 = done_cnt;
        bit left = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (state_dbg != ST_DRAIN) begin
                left = 1'b1;
                break;
            end
            n++;
            if (n == 1)
                check("drain_edges_zero", {west0, west1, west2, west3, north0, north1, north2, north3} == '0 ? 128'(1) : 128'(0), 128'(1));
            if (n == done_at) arr_done = 1'b1;
        end
        arr_done = 1'b0;
        check("drain_exit_in_bound", 128'(left), 128'(1));
        exp_n = (done_at == 0) ? 64 : done_at;
        check("drain_cycles", 128'(n), 128'(exp_n));
        check("exit_state", 128'(state_dbg), expect_err ? 128'(ST_ERR) : 128'(ST_FINISH));
        check("exit_busy", 128'(busy), 128'(1));
        check("exit_done", 128'(done), expect_err ? 128'(0) : 128'(1));
        check("exit_err", 128'(err), expect_err ? 128'(1) : 128'(0));
        @(negedge clk);
        check("idle_state", 128'(state_dbg), 128'(ST_IDLE));
        check("idle_busy", 128'(busy), 128'(0));
        check("idle_done", 128'(done), 128'(0));
        check("idle_arr_rst", 128'(arr_rst), 128'(1));
        check("idle_err", 128'(err), expect_err ? 128'(1) : 128'(0));
        check("done_pulses", 128'(done_cnt - d0), expect_err ? 128'(0) : 128'(1));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        // Test 1 vectors: A row0 = {3,2,1,0}, B col0 = {12,8,4,0}.
        tbl[0] = '{w: pack4(3, 0, 0, 0), n: pack4(12, 0, 0, 0)};
        tbl[1] = '{w: pack4(2, 0, 0, 0), n: pack4(8, 0, 0, 0)};
        tbl[2] = '{w: pack4(1, 0, 0, 0), n: pack4(4, 0, 0, 0)};
        for (int t = 3; t < 7; t++) tbl[t] = '{w: '0, n: '0};
        // Test 2 vectors: A[i][k] = 4i+k+1, B[k][j] = 4k+j+1.
        tbl[7]  = '{w: pack4(1, 0, 0, 0),    n: pack4(1, 0, 0, 0)};
        tbl[8]  = '{w: pack4(2, 5, 0, 0),    n: pack4(5, 2, 0, 0)};
        tbl[9]  = '{w: pack4(3, 6, 9, 0),    n: pack4(9, 6, 3, 0)};
        tbl[10] = '{w: pack4(4, 7, 10, 13),  n: pack4(13, 10, 7, 4)};
        tbl[11] = '{w: pack4(0, 8, 11, 14),  n: pack4(0, 14, 11, 8)};
        tbl[12] = '{w: pack4(0, 0, 12, 15),  n: pack4(0, 0, 15, 12)};
        tbl[13] = '{w: pack4(0, 0, 0, 16),   n: pack4(0, 0, 0, 16)};
        // All-zero vectors after a reset wiped the matrices.
        for (int t = 14; t < 21; t++) tbl[t] = '{w: '0, n: '0};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_state0", 128'(state_dbg), 128'(ST_IDLE));
        check("rst_flags0", 128'({busy, done, err, arr_rst}), 128'(4'b0001));
        check("rst_edges0", {west0, west1, west2, west3}, '0);
        rst = 1'b1;

        // Test 1: single row/column, normal completion
        write_op(1'b0, 0, 0, 3, 1'b0);
        write_op(1'b0, 0, 1, 2, 1'b0);
        write_op(1'b0, 0, 2, 1, 1'b0);
        write_op(1'b1, 0, 0, 12, 1'b0);
        write_op(1'b1, 1, 0, 8, 1'b0);
        write_op(1'b1, 2, 0, 4, 1'b0);
        pulse_start();
        run_feed(0, -5, -5);
        drain(1, 1'b0);

        // Test 2: full skew; the last write shares its cycle with start
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 4; k++) begin
                write_op(1'b0, i, k, 4 * i + k + 1, 1'b0);
                if (!(i == 3 && k == 3)) write_op(1'b1, i, k, 4 * i + k + 1, 1'b0);
            end
        write_op(1'b1, 3, 3, 16, 1'b1);
        run_feed(7, -5, -5);
        drain(1, 1'b0);

        // Test 3: timeout with arr_done held low
        pulse_start();
        run_feed(7, -5, -5);
        drain(0, 1'b1);
        repeat (2) @(negedge clk);
        check("err_sticky", 128'(err), 128'(1));

        // Test 4: next start clears err; write and start during FEED ignored
        pulse_start();
        check("err_cleared", 128'(err), 128'(0));
        run_feed(7, 2, -5);
        drain(1, 1'b0);
        repeat (2) @(negedge clk);
        check("no_restart", 128'(state_dbg), 128'(ST_IDLE));
        pulse_start();
        run_feed(7, -5, -5);
        drain(1, 1'b0);

        // Test 6: arr_done on the cycle the timeout is reached
        pulse_start();
        run_feed(7, -5, -5);
        drain(64, 1'b0);

        // Test 5: asynchronous reset at FEED t=3, then a run on cleared matrices
        pulse_start();
        run_feed(7, -5, 3);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_state", 128'(state_dbg), 128'(ST_IDLE));
        pulse_start();
        run_feed(14, -5, -5);
        drain(1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/systolic_array_ctrl.md
Name: systolic_array_ctrl

Overview:
- Sequencer for the 4x4 `systolic_array` datapath. Holds operand matrices A (west side) and B (north side) in local register files.
- On a start request it clears the array, then streams skewed operands onto the 8 edge inputs. It waits for the array's `done`, or a timeout, and reports completion with a single-cycle pulse.
- Replaces hand-written skewed stimulus; sits between a host-side write/start interface and the array.

Parameters:
- DW, 32, operand width; matches array edge ports.
- N, 4, array dimension; fixed at 4, because the array has exactly 4 west and 4 north ports.
- TIMEOUT, 64, maximum cycles in DRAIN waiting for `arr_done` before an error is flagged.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; asynchronous, active-low.
- wr_en  in  1  operand write strobe.
- wr_sel  in  1  0 = write A, 1 = write B.
- wr_row  in  2  row index.
- wr_col  in  2  column index.
- wr_data  in  DW  operand value.
- start  in  1  begin a matrix multiply; sampled in IDLE only.
- busy  out  1  high from the cycle after start is accepted until FINISH/ERR exits.
- done  out  1  one-cycle pulse on successful completion.
- err  out  1  sticky timeout flag; cleared by the next accepted start.
- arr_rst  out  1  active-high clear to the array.
- arr_done  in  1  array's done output.
- west0..west3  out  DW each  array west inputs.
- north0..north3  out  DW each  array north inputs.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; busy=0, done=0, err=0, arr_rst=1.
  - All west/north outputs = 0; step and timeout counters = 0.
  - A/B register files cleared to 0.
- All outputs are registered.
- Writes: on a clock edge with wr_en=1 and busy=0, the selected matrix element [wr_row][wr_col] <= wr_data.
  - wr_en while busy=1 is ignored; stored operands are unchanged.
- States: IDLE -> CLR -> FEED -> DRAIN -> FINISH -> IDLE; DRAIN -> ERR -> IDLE.
- IDLE:
  - arr_rst=1; edge outputs 0.
  - start=1 at an edge -> CLR, and err<=0.
  - wr_en and start in the same cycle: the write completes, then start is accepted.
- CLR (1 cycle): busy=1, arr_rst=1, edge outputs 0 -> FEED with step t=0.
- FEED (2N-1 = 7 cycles, t = 0..6):
  - arr_rst=0.
  - During step t: west_i = A[i][t-i] if 0 <= t-i < N, else 0; north_j = B[t-j][j] if 0 <= t-j < N, else 0.
  - Values are presented for the full cycle of step t.
  - After t=6 -> DRAIN.
- DRAIN:
  - Edge outputs 0; timeout counter increments each cycle.
  - arr_done=1 -> FINISH. This takes priority if it coincides with reaching TIMEOUT.
  - Counter reaches TIMEOUT with arr_done=0 -> ERR.
- FINISH (1 cycle): done=1, busy=1 -> IDLE. done is 0 in every other state.
- ERR (1 cycle): err<=1, busy=1 -> IDLE. err holds until the next accepted start or reset.
- start outside IDLE is ignored (no queuing).
- arr_done outside DRAIN is ignored.
- Reset asserted mid-operation:
  - Immediate return to IDLE with reset values.
  - arr_rst asserts asynchronously with rst; operands are lost.
- Latency: start edge -> first operand on edges is 2 cycles (CLR, then FEED t=0). Minimum start -> done is 1 + 7 + 1 (DRAIN) + 1 = 10 cycles.
- Arithmetic: pure indexing; no arithmetic on operand data. Counters:
  - step counter: 3 bits, saturates at 6.
  - timeout counter: clog2(TIMEOUT+1) bits, saturating.

Test Plan:
1. Write A row0 = {3,2,1,0} and B col0 = {12,8,4,0}; other entries 0; pulse start.
   -> west0 = 3,2,1,0 on FEED t=0..3; north0 = 12,8,4,0 on t=0..3; west1..3 and north1..3 all 0.
   -> With the real array: result for element (0,0) = 56, done pulses once, err=0.
2. Full skew check: A[i][k] = 4i+k+1, B[k][j] = 4k+j+1.
   -> At t=3: west = {4,7,10,13}, north = {13,10,7,4}.
   -> At t=6: west3 = 16, north3 = 16, all other edge outputs 0.
3. Hold arr_done=0 in DRAIN.
   -> After TIMEOUT=64 cycles: err=1, done never pulses, busy drops, state IDLE.
   -> Next start clears err to 0.
4. Assert wr_en (A[0][0] <= 99) and start pulses during FEED.
   -> Stored A[0][0] unchanged; no restart.
   -> A later run shows the original value on west0 at t=0.
5. Drive rst=0 at FEED t=3, asynchronously mid-cycle.
   -> Outputs zero and arr_rst=1 before the next edge; busy=0.
   -> After release: IDLE, matrices read back as 0.
6. arr_done=1 on the same cycle the timeout counter hits TIMEOUT.
   -> done=1, err stays 0.
